// File: rtl/sid_multi_voice_filter.sv
`default_nettype none
// ============================================================================
//  Module      : sid_multi_voice_filter
//  Description : Time-multiplexed state-variable filter for NUM_VOICES SID
//                voices. The voices share one saturating multiplier, and each
//                voice keeps its own hp/bp/lp state. The filtered voices are
//                mixed into one saturated sample per sample frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module sid_multi_voice_filter #(
   parameter int NUM_VOICES         = 3,
   parameter int AUDIO_BDEPTH       = 12,
   parameter int AUDIO_OUT_BDEPTH   = 12,
   parameter int FILTER_BDEPTH      = 16,
   parameter int FILTER_COEF_BDEPTH = 16,
   parameter int INPUT_GAIN_BITS    = 4,
   parameter int OUTPUT_GAIN_BITS   = 6,
   parameter int F_SHIFT            = 16,
   parameter int Q_SHIFT            = 12
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       sample_strobe,
   input  logic [NUM_VOICES*AUDIO_BDEPTH-1:0]         audio_in,
   input  logic [NUM_VOICES*FILTER_COEF_BDEPTH-1:0]   f_coefficient,
   input  logic [NUM_VOICES*FILTER_COEF_BDEPTH-1:0]   q_coefficient,
   input  logic [NUM_VOICES*4-1:0]                    mode,
   output logic signed [AUDIO_OUT_BDEPTH-1:0]         audio_out,
   output logic                                       out_valid,
   output logic                                       busy,
   output logic                                       overrun
);

   // Wide working width: holds any product, shifted input or accumulator
   // value without overflow, so saturation is a plain compare.
   localparam int WW = FILTER_COEF_BDEPTH + FILTER_BDEPTH + AUDIO_BDEPTH + INPUT_GAIN_BITS + 8;
   localparam int AW = FILTER_BDEPTH + 6;
   localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   localparam logic signed [WW-1:0] F_MAX = {{(WW-FILTER_BDEPTH+1){1'b0}}, {(FILTER_BDEPTH-1){1'b1}}};
   localparam logic signed [WW-1:0] F_MIN = {{(WW-FILTER_BDEPTH+1){1'b1}}, {(FILTER_BDEPTH-1){1'b0}}};
   localparam logic signed [WW-1:0] O_MAX = {{(WW-AUDIO_OUT_BDEPTH+1){1'b0}}, {(AUDIO_OUT_BDEPTH-1){1'b1}}};
   localparam logic signed [WW-1:0] O_MIN = {{(WW-AUDIO_OUT_BDEPTH+1){1'b1}}, {(AUDIO_OUT_BDEPTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MUL_Q  = 3'd1,
      S_MUL_FH = 3'd2,
      S_MUL_FB = 3'd3,
      S_WB     = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   function automatic logic signed [FILTER_BDEPTH-1:0] sat_f(input logic signed [WW-1:0] v);
      if (v > F_MAX)      return F_MAX[FILTER_BDEPTH-1:0];
      else if (v < F_MIN) return F_MIN[FILTER_BDEPTH-1:0];
      else                return v[FILTER_BDEPTH-1:0];
   endfunction

   function automatic logic signed [AUDIO_OUT_BDEPTH-1:0] sat_o(input logic signed [WW-1:0] v);
      if (v > O_MAX)      return O_MAX[AUDIO_OUT_BDEPTH-1:0];
      else if (v < O_MIN) return O_MIN[AUDIO_OUT_BDEPTH-1:0];
      else                return v[AUDIO_OUT_BDEPTH-1:0];
   endfunction

   state_t state_q, state_d;
   logic [VW-1:0] v_q, v_d;
   logic [NUM_VOICES*AUDIO_BDEPTH-1:0]       audio_sh_q, audio_sh_d;
   logic [NUM_VOICES*FILTER_COEF_BDEPTH-1:0] f_sh_q, f_sh_d;
   logic [NUM_VOICES*FILTER_COEF_BDEPTH-1:0] q_sh_q, q_sh_d;
   logic [NUM_VOICES*4-1:0]                  mode_sh_q, mode_sh_d;
   logic signed [FILTER_BDEPTH-1:0] hp1_q [NUM_VOICES];
   logic signed [FILTER_BDEPTH-1:0] hp1_d [NUM_VOICES];
   logic signed [FILTER_BDEPTH-1:0] bp1_q [NUM_VOICES];
   logic signed [FILTER_BDEPTH-1:0] bp1_d [NUM_VOICES];
   logic signed [FILTER_BDEPTH-1:0] lp1_q [NUM_VOICES];
   logic signed [FILTER_BDEPTH-1:0] lp1_d [NUM_VOICES];
   logic signed [FILTER_BDEPTH-1:0] qb_q, qb_d, fh_q, fh_d, fb_q, fb_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [AUDIO_OUT_BDEPTH-1:0] audio_out_q, audio_out_d;
   logic out_valid_q, out_valid_d, overrun_q, overrun_d;

   // Current-voice operands and the shared multiplier datapath
   logic signed [AUDIO_BDEPTH-1:0]   audio_v;
   logic [FILTER_COEF_BDEPTH-1:0]    f_v, q_v, coef_sel;
   logic [3:0]                       mode_v;
   logic signed [FILTER_BDEPTH-1:0]  x_w, hp_w, bp_v, lp_v, opnd_sel, mult_sat;
   logic signed [FILTER_BDEPTH-1:0]  bp_new, lp_new;
   logic signed [WW-1:0]             prod_w;

   // Voice operand selection, shared multiplier and per-voice arithmetic
   always_comb begin
      audio_v = $signed(audio_sh_q[v_q*AUDIO_BDEPTH +: AUDIO_BDEPTH]);
      f_v     = f_sh_q[v_q*FILTER_COEF_BDEPTH +: FILTER_COEF_BDEPTH];
      q_v     = q_sh_q[v_q*FILTER_COEF_BDEPTH +: FILTER_COEF_BDEPTH];
      mode_v  = mode_sh_q[v_q*4 +: 4];
      bp_v    = bp1_q[v_q];
      lp_v    = lp1_q[v_q];
      x_w     = sat_f(WW'(audio_v) <<< INPUT_GAIN_BITS);
      hp_w    = sat_f(WW'(x_w) - WW'(sat_f(WW'(qb_q) + WW'(lp_v))));
      // q * bp in MUL_Q, f * hp in MUL_FH, f * old bp otherwise
      coef_sel = f_v;
      opnd_sel = bp_v;
      if (state_q == S_MUL_Q) begin
         coef_sel = q_v;
      end else if (state_q == S_MUL_FH) begin
         opnd_sel = hp_w;
      end
      prod_w   = WW'($signed({1'b0, coef_sel})) * WW'(opnd_sel);
      mult_sat = (state_q == S_MUL_Q) ? sat_f(prod_w >>> Q_SHIFT) : sat_f(prod_w >>> F_SHIFT);
      bp_new   = sat_f(WW'(bp_v) + WW'(fh_q));
      lp_new   = sat_f(WW'(lp_v) + WW'(fb_q));
   end

   // Next-state logic: frame sequencing, state update and mixing
   always_comb begin
      state_d     = state_q;
      v_d         = v_q;
      audio_sh_d  = audio_sh_q;
      f_sh_d      = f_sh_q;
      q_sh_d      = q_sh_q;
      mode_sh_d   = mode_sh_q;
      hp1_d       = hp1_q;
      bp1_d       = bp1_q;
      lp1_d       = lp1_q;
      qb_d        = qb_q;
      fh_d        = fh_q;
      fb_d        = fb_q;
      acc_d       = acc_q;
      audio_out_d = audio_out_q;
      out_valid_d = 1'b0;
      overrun_d   = sample_strobe && (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (sample_strobe) begin
               audio_sh_d = audio_in;
               f_sh_d     = f_coefficient;
               q_sh_d     = q_coefficient;
               mode_sh_d  = mode;
               acc_d      = '0;
               v_d        = '0;
               state_d    = S_MUL_Q;
            end
         end
         S_MUL_Q: begin
            qb_d    = mult_sat;
            state_d = S_MUL_FH;
         end
         S_MUL_FH: begin
            // hp is parked in its per-voice slot so WB can mix it
            fh_d          = mult_sat;
            hp1_d[v_q]    = hp_w;
            state_d       = S_MUL_FB;
         end
         S_MUL_FB: begin
            fb_d    = mult_sat;
            state_d = S_WB;
         end
         S_WB: begin
            bp1_d[v_q] = bp_new;
            lp1_d[v_q] = lp_new;
            // At most 4*8 terms of 16 bits: the accumulator cannot overflow
            acc_d = acc_q
                  + (mode_v[0] ? AW'(x_w)        : AW'(0))
                  + (mode_v[1] ? AW'(lp_new)     : AW'(0))
                  + (mode_v[2] ? AW'(bp_new)     : AW'(0))
                  + (mode_v[3] ? AW'(hp1_q[v_q]) : AW'(0));
            if (v_q == VW'(NUM_VOICES-1)) begin
               // Output registers load on entry to DONE so they are visible in DONE
               audio_out_d = sat_o(WW'(sat_f(WW'(acc_d))) >>> OUTPUT_GAIN_BITS);
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               v_d     = v_q + VW'(1);
               state_d = S_MUL_Q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         v_q         <= '0;
         audio_sh_q  <= '0;
         f_sh_q      <= '0;
         q_sh_q      <= '0;
         mode_sh_q   <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            hp1_q[i] <= '0;
            bp1_q[i] <= '0;
            lp1_q[i] <= '0;
         end
         qb_q        <= '0;
         fh_q        <= '0;
         fb_q        <= '0;
         acc_q       <= '0;
         audio_out_q <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         v_q         <= v_d;
         audio_sh_q  <= audio_sh_d;
         f_sh_q      <= f_sh_d;
         q_sh_q      <= q_sh_d;
         mode_sh_q   <= mode_sh_d;
         hp1_q       <= hp1_d;
         bp1_q       <= bp1_d;
         lp1_q       <= lp1_d;
         qb_q        <= qb_d;
         fh_q        <= fh_d;
         fb_q        <= fb_d;
         acc_q       <= acc_d;
         audio_out_q <= audio_out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign audio_out = audio_out_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sid_multi_voice_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sid_multi_voice_filter
//  Description : Scoreboard bench for sid_multi_voice_filter with directed
//                frames and randomized frames against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sid_multi_voice_filter;

   localparam int N = 3, AB = 12, OB = 12, FB = 16, CB = 16;
   localparam int IG = 4, OG = 6, FS = 16, QS = 12;
   localparam int LAT = 4*N + 1;
   localparam int PERIOD = 4*N + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sample_strobe = 1'b0;
   logic [N*AB-1:0] audio_in = '0;
   logic [N*CB-1:0] f_coefficient = '0;
   logic [N*CB-1:0] q_coefficient = '0;
   logic [N*4-1:0]  mode = '0;
   logic signed [OB-1:0] audio_out;
   logic out_valid, busy, overrun;

   sid_multi_voice_filter #(
      .NUM_VOICES(N), .AUDIO_BDEPTH(AB), .AUDIO_OUT_BDEPTH(OB),
      .FILTER_BDEPTH(FB), .FILTER_COEF_BDEPTH(CB),
      .INPUT_GAIN_BITS(IG), .OUTPUT_GAIN_BITS(OG),
      .F_SHIFT(FS), .Q_SHIFT(QS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe),
      .audio_in(audio_in), .f_coefficient(f_coefficient),
      .q_coefficient(q_coefficient), .mode(mode),
      .audio_out(audio_out), .out_valid(out_valid),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int exp_val_q[$];
   int exp_cyc_q[$];
   int ovr_seen = 0;
   int ovr_exp = 0;

   // Reference filter state, one entry per voice
   longint m_bp[N];
   longint m_lp[N];

   function automatic longint sat(input longint v, input int w);
      longint mx, mn;
      mx = (longint'(1) <<< (w-1)) - 1;
      mn = -(longint'(1) <<< (w-1));
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
   endfunction

   function automatic int model_frame(input logic [N*AB-1:0] a, input logic [N*CB-1:0] f,
                                      input logic [N*CB-1:0] q, input logic [N*4-1:0] m);
      longint acc, x, fv, qv, qb, hp, fh, fb, bp, lp, mix;
      logic signed [AB-1:0] s;
      logic [3:0] mv;
      acc = 0;
      for (int v = 0; v < N; v++) begin
         s  = $signed(a[v*AB +: AB]);
         x  = sat(longint'(s) * (longint'(1) <<< IG), FB);
         fv = longint'(f[v*CB +: CB]);
         qv = longint'(q[v*CB +: CB]);
         mv = m[v*4 +: 4];
         qb = sat((qv * m_bp[v]) >>> QS, FB);
         hp = sat(x - sat(qb + m_lp[v], FB), FB);
         fh = sat((fv * hp) >>> FS, FB);
         fb = sat((fv * m_bp[v]) >>> FS, FB);
         bp = sat(m_bp[v] + fh, FB);
         lp = sat(m_lp[v] + fb, FB);
         m_bp[v] = bp;
         m_lp[v] = lp;
         if (mv[0]) acc += x;
         if (mv[1]) acc += lp;
         if (mv[2]) acc += bp;
         if (mv[3]) acc += hp;
      end
      mix = sat(acc, FB);
      return int'(sat(mix >>> OG, OB));
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic junk_inputs();
      for (int v = 0; v < N; v++) begin
         audio_in[v*AB +: AB]      = AB'($urandom);
         f_coefficient[v*CB +: CB] = CB'($urandom);
         q_coefficient[v*CB +: CB] = CB'($urandom);
         mode[v*4 +: 4]            = 4'($urandom);
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int v = 0; v < N; v++) begin
         m_bp[v] = 0;
         m_lp[v] = 0;
      end
   endtask

   // One frame: strobe with the given inputs, scramble inputs while busy,
   // optionally fire an extra strobe at frame cycle ovr_at (1..PERIOD-1).
   task automatic do_frame(input logic [N*AB-1:0] a, input logic [N*CB-1:0] f,
                           input logic [N*CB-1:0] q, input logic [N*4-1:0] m,
                           input int ovr_at, input bit use_const, input int const_exp);
      int e;
      @(negedge clk);
      check("busy_idle", busy, 0);
      audio_in = a; f_coefficient = f; q_coefficient = q; mode = m;
      sample_strobe = 1'b1;
      e = model_frame(a, f, q, m);
      exp_val_q.push_back(use_const ? const_exp : e);
      exp_cyc_q.push_back(cyc + LAT);
      for (int c = 1; c < PERIOD; c++) begin
         @(negedge clk);
         sample_strobe = (c == ovr_at);
         if (c == ovr_at) ovr_exp++;
         junk_inputs();
         if (c == 1) check("busy_run", busy, 1);
      end
      @(negedge clk);
      sample_strobe = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every out_valid and counts overruns
   always @(negedge clk) begin
      if (rst_n) begin
         if (overrun) ovr_seen++;
         if (out_valid) begin
            if (exp_val_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out_valid: got audio_out %0d with nothing expected (t=%0t)",
                        audio_out, $time);
            end else begin
               check("audio_out", audio_out, exp_val_q.pop_front());
               check("latency", cyc, exp_cyc_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [N*AB-1:0] a;
      logic [N*CB-1:0] f, q;
      logic [N*4-1:0]  m;
      int ovr;

      for (int v = 0; v < N; v++) begin m_bp[v] = 0; m_lp[v] = 0; end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset: nothing moves
      repeat (50) begin
         @(negedge clk);
         check("idle_out_valid", out_valid, 0);
         check("idle_busy", busy, 0);
         check("idle_audio_out", audio_out, 0);
      end

      // Highpass, f=q=0: x = 1600, out = 25, repeatable
      a = '0; f = '0; q = '0; m = '0;
      a[0 +: AB] = 12'sd100; m[3:0] = 4'b1000;
      do_frame(a, f, q, m, 0, 1, 25);
      do_frame(a, f, q, m, 0, 1, 25);

      // Pass-through saturation on the mix
      reset_dut();
      m = '0;
      for (int v = 0; v < N; v++) begin a[v*AB +: AB] = 12'sd2047; m[v*4 +: 4] = 4'b0001; end
      do_frame(a, f, q, m, 0, 1, 511);
      for (int v = 0; v < N; v++) a[v*AB +: AB] = -12'sd2048;
      do_frame(a, f, q, m, 0, 1, -512);

      // Lowpass integration over two frames
      reset_dut();
      a = '0; f = '0; q = '0; m = '0;
      a[0 +: AB] = 12'sd100; f[0 +: CB] = 16'd16384; m[3:0] = 4'b0010;
      do_frame(a, f, q, m, 0, 1, 0);
      do_frame(a, f, q, m, 0, 1, 1);

      // Damping: second frame hp = 1600 - 400
      reset_dut();
      q[0 +: CB] = 16'd4096; m[3:0] = 4'b1000;
      do_frame(a, f, q, m, 0, 1, 25);
      do_frame(a, f, q, m, 0, 1, 18);

      // Overrun: extra strobe 5 cycles in, frame result unaffected
      reset_dut();
      q = '0; f = '0;
      do_frame(a, f, q, m, 5, 1, 25);

      // Reset in the middle of a frame aborts it
      @(negedge clk);
      audio_in = a; f_coefficient = f; q_coefficient = q; mode = m;
      sample_strobe = 1'b1;
      @(negedge clk);
      sample_strobe = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("reset_busy", busy, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_audio_out", audio_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int v = 0; v < N; v++) begin m_bp[v] = 0; m_lp[v] = 0; end
      repeat (PERIOD) @(negedge clk);
      // Filter state cleared: lowpass frame from zero state gives 0 then 1
      a = '0; f = '0; q = '0; m = '0;
      a[0 +: AB] = 12'sd100; f[0 +: CB] = 16'd16384; m[3:0] = 4'b0010;
      do_frame(a, f, q, m, 0, 1, 0);
      do_frame(a, f, q, m, 0, 1, 1);

      // Randomized frames against the model
      for (int k = 0; k < 150; k++) begin
         for (int v = 0; v < N; v++) begin
            a[v*AB +: AB] = AB'($urandom);
            f[v*CB +: CB] = ($urandom_range(0, 1) == 0) ? CB'($urandom_range(0, 8191)) : CB'($urandom);
            q[v*CB +: CB] = ($urandom_range(0, 1) == 0) ? CB'($urandom_range(0, 8191)) : CB'($urandom);
            m[v*4 +: 4]   = 4'($urandom);
         end
         ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, PERIOD-1)) : 0;
         do_frame(a, f, q, m, ovr, 0, 0);
      end

      repeat (PERIOD + 2) @(negedge clk);
      check("scoreboard_drained", exp_val_q.size(), 0);
      check("overrun_count", ovr_seen, ovr_exp);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
